collision_sequencer: RTL and testbench

Frame-rate collision controller for the road section of the game. Once per frame it snapshots the player and car positions, then tests them against one shared rectangle-overlap comparator, one car per clock. It turns the first detected overlap into a hit event, manages lives, the respawn request, the post-hit invulnerability window and the sticky game-over state. It sits between the position/movement logic and the game-state/rendering logic.

---
 rtl/collision_sequencer_pkg.sv | 43 ++++
 rtl/collision_sequencer_overlap.sv | 31 +++
 rtl/collision_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_collision_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_sequencer_pkg.sv
// Shared constants, state encoding and payload types for the collision sequencer.
// Sprite sizes and the lane y table live here so the sequencer and comparator agree.
package collision_sequencer_pkg;

   localparam int unsigned POS_W         = 10;
   localparam int unsigned SUM_W         = 11;
   localparam int unsigned IDX_W         = 3;
   localparam int unsigned INV_W         = 8;

   localparam int unsigned CAR_WIDTH     = 32;
   localparam int unsigned CAR_HEIGHT    = 32;
   localparam int unsigned PLAYER_WIDTH  = 32;
   localparam int unsigned PLAYER_HEIGHT = 32;

   localparam int unsigned CAR_Y1        = 100;
   localparam int unsigned CAR_Y2        = 180;
   localparam int unsigned CAR_Y3        = 260;
   localparam int unsigned CAR_Y4        = 340;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DECIDE = 2'd2
   } state_t;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
   } rect_pos_t;

   // Lanes 4..7 reuse the four-entry table.
   function automatic logic [POS_W-1:0] lane_y(input logic [IDX_W-1:0] idx);
      logic [POS_W-1:0] y;
      case (idx)
         3'd0, 3'd4: y = POS_W'(CAR_Y1);
         3'd1, 3'd5: y = POS_W'(CAR_Y2);
         3'd2, 3'd6: y = POS_W'(CAR_Y3);
         default:    y = POS_W'(CAR_Y4);
      endcase
      return y;
   endfunction

endpackage

// File: rtl/collision_sequencer_overlap.sv
// rect_overlap: combinational strict-inequality overlap test of two rectangles.
// Edges are widened to 11 bits so right/bottom edges near 1023 never wrap.
module rect_overlap
   import collision_sequencer_pkg::*;
#(
   parameter int unsigned A_W = PLAYER_WIDTH,
   parameter int unsigned A_H = PLAYER_HEIGHT,
   parameter int unsigned B_W = CAR_WIDTH,
   parameter int unsigned B_H = CAR_HEIGHT
) (
   input  rect_pos_t i_a,
   input  rect_pos_t i_b,
   output logic      o_overlap_c
);

   logic [SUM_W-1:0] w_ax, w_ay, w_bx, w_by;
   logic [SUM_W-1:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

   assign w_ax     = SUM_W'(i_a.x);
   assign w_ay     = SUM_W'(i_a.y);
   assign w_bx     = SUM_W'(i_b.x);
   assign w_by     = SUM_W'(i_b.y);
   assign w_ax_end = w_ax + SUM_W'(A_W);
   assign w_ay_end = w_ay + SUM_W'(A_H);
   assign w_bx_end = w_bx + SUM_W'(B_W);
   assign w_by_end = w_by + SUM_W'(B_H);

   assign o_overlap_c = (w_ax < w_bx_end) && (w_ax_end > w_bx) &&
                        (w_ay < w_by_end) && (w_ay_end > w_by);

endmodule

// File: rtl/collision_sequencer.sv
// Per-frame collision scan: snapshot positions, test one car per clock, then apply hit/lives.
// Optional post-hit invulnerability counter is built when COLLISION_INVULN_EN is defined.
module collision_sequencer
   import collision_sequencer_pkg::*;
#(
   parameter int unsigned NUM_CARS      = 4,
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned LIVES_W       = 2,
   parameter int unsigned INVULN_FRAMES = 60
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_tick,
   input  logic                      restart,
   input  logic [POS_W-1:0]          player_x,
   input  logic [POS_W-1:0]          player_y,
   input  logic [POS_W*NUM_CARS-1:0] car_x,
   output logic                      hit,
   output logic [IDX_W-1:0]          hit_car,
   output logic                      respawn,
   output logic [LIVES_W-1:0]        lives,
   output logic                      invuln,
   output logic                      game_over,
   output logic                      busy,
   output logic                      overrun
);

   if (NUM_CARS < 1 || NUM_CARS > 8) begin : g_bad_num_cars
      $error("collision_sequencer: NUM_CARS out of range");
   end
   if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln
      $error("collision_sequencer: INVULN_FRAMES out of range");
   end

   state_t                    r_state, w_state_nxt;
   logic [IDX_W-1:0]          r_idx, w_idx_nxt;
   logic                      r_any_hit, w_any_hit_nxt;
   logic [IDX_W-1:0]          r_first_idx, w_first_idx_nxt;
   logic [POS_W-1:0]          r_px, w_px_nxt;
   logic [POS_W-1:0]          r_py, w_py_nxt;
   logic [POS_W*NUM_CARS-1:0] r_car_x, w_car_x_nxt;
   logic                      r_hit, w_hit_nxt;
   logic                      r_respawn, w_respawn_nxt;
   logic [IDX_W-1:0]          r_hit_car, w_hit_car_nxt;
   logic [LIVES_W-1:0]        r_lives, w_lives_nxt, w_lives_dec;
   logic                      r_game_over, w_game_over_nxt;
   logic                      r_busy, w_busy_nxt;
   logic                      r_overrun, w_overrun_nxt;
`ifdef COLLISION_INVULN_EN
   logic [INV_W-1:0]          r_inv_cnt, w_inv_cnt_nxt;
   logic                      r_invuln, w_invuln_nxt;
`endif

   logic [POS_W-1:0]          w_car_sel;
   logic                      w_overlap;
   rect_pos_t                 w_player_rect, w_car_rect;

   // Car x mux for the lane currently being scanned.
   always_comb begin
      w_car_sel = '0;
      for (int i = 0; i < int'(NUM_CARS); i++) begin
         if (r_idx == IDX_W'(i)) w_car_sel = r_car_x[i*POS_W +: POS_W];
      end
   end

   assign w_player_rect = '{x: r_px, y: r_py};
   assign w_car_rect    = '{x: w_car_sel, y: lane_y(r_idx)};
   assign w_lives_dec   = r_lives - LIVES_W'(1);

   rect_overlap u_overlap (
      .i_a         (w_player_rect),
      .i_b         (w_car_rect),
      .o_overlap_c (w_overlap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_any_hit   <= 1'b0;
         r_first_idx <= '0;
         r_px        <= '0;
         r_py        <= '0;
         r_car_x     <= '0;
         r_hit       <= 1'b0;
         r_respawn   <= 1'b0;
         r_hit_car   <= '0;
         r_lives     <= LIVES_W'(START_LIVES);
         r_game_over <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef COLLISION_INVULN_EN
         r_inv_cnt   <= '0;
         r_invuln    <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_any_hit   <= w_any_hit_nxt;
         r_first_idx <= w_first_idx_nxt;
         r_px        <= w_px_nxt;
         r_py        <= w_py_nxt;
         r_car_x     <= w_car_x_nxt;
         r_hit       <= w_hit_nxt;
         r_respawn   <= w_respawn_nxt;
         r_hit_car   <= w_hit_car_nxt;
         r_lives     <= w_lives_nxt;
         r_game_over <= w_game_over_nxt;
         r_busy      <= w_busy_nxt;
         r_overrun   <= w_overrun_nxt;
`ifdef COLLISION_INVULN_EN
         r_inv_cnt   <= w_inv_cnt_nxt;
         r_invuln    <= w_invuln_nxt;
`endif
      end
   end

   // Next-state and next-output logic; restart overrides everything including a same-cycle tick.
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_any_hit_nxt   = r_any_hit;
      w_first_idx_nxt = r_first_idx;
      w_px_nxt        = r_px;
      w_py_nxt        = r_py;
      w_car_x_nxt     = r_car_x;
      w_hit_nxt       = 1'b0;
      w_respawn_nxt   = 1'b0;
      w_hit_car_nxt   = r_hit_car;
      w_lives_nxt     = r_lives;
      w_game_over_nxt = r_game_over;
      w_overrun_nxt   = r_overrun;
`ifdef COLLISION_INVULN_EN
      w_inv_cnt_nxt   = r_inv_cnt;
`endif

      if (restart) begin
         w_state_nxt     = ST_IDLE;
         w_idx_nxt       = '0;
         w_any_hit_nxt   = 1'b0;
         w_hit_car_nxt   = '0;
         w_lives_nxt     = LIVES_W'(START_LIVES);
         w_game_over_nxt = 1'b0;
         w_overrun_nxt   = 1'b0;
`ifdef COLLISION_INVULN_EN
         w_inv_cnt_nxt   = '0;
`endif
      end else begin
         if (frame_tick && (r_state != ST_IDLE)) w_overrun_nxt = 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (frame_tick) begin
                  w_state_nxt   = ST_SCAN;
                  w_px_nxt      = player_x;
                  w_py_nxt      = player_y;
                  w_car_x_nxt   = car_x;
                  w_idx_nxt     = '0;
                  w_any_hit_nxt = 1'b0;
               end
            end
            ST_SCAN: begin
               if (w_overlap && !r_any_hit) begin
                  w_any_hit_nxt   = 1'b1;
                  w_first_idx_nxt = r_idx;
               end
               if (r_idx == IDX_W'(NUM_CARS - 1)) w_state_nxt = ST_DECIDE;
               else                              w_idx_nxt   = r_idx + IDX_W'(1);
            end
            ST_DECIDE: begin
               w_state_nxt = ST_IDLE;
               if (!r_game_over) begin
`ifdef COLLISION_INVULN_EN
                  if (r_inv_cnt != '0) w_inv_cnt_nxt = r_inv_cnt - INV_W'(1);
                  else
`endif
                  if (r_any_hit) begin
                     w_hit_nxt     = 1'b1;
                     w_hit_car_nxt = r_first_idx;
                     w_lives_nxt   = w_lives_dec;
                     if (w_lives_dec == '0) begin
                        w_game_over_nxt = 1'b1;
                     end else begin
                        w_respawn_nxt = 1'b1;
`ifdef COLLISION_INVULN_EN
                        w_inv_cnt_nxt = INV_W'(INVULN_FRAMES);
`endif
                     end
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end

      w_busy_nxt = (w_state_nxt != ST_IDLE);
`ifdef COLLISION_INVULN_EN
      w_invuln_nxt = (w_inv_cnt_nxt != '0);
`endif
   end

   assign hit       = r_hit;
   assign hit_car   = r_hit_car;
   assign respawn   = r_respawn;
   assign lives     = r_lives;
   assign game_over = r_game_over;
   assign busy      = r_busy;
   assign overrun   = r_overrun;
`ifdef COLLISION_INVULN_EN
   assign invuln    = r_invuln;
`else
   assign invuln    = 1'b0;
`endif

endmodule

// File: tb/tb_collision_sequencer.sv
// Self-checking bench for collision_sequencer: overlap vector table plus multi-frame sequences.
module tb_collision_sequencer;

   localparam int unsigned NUM_CARS      = 4;
   localparam int unsigned START_LIVES   = 3;
   localparam int unsigned LIVES_W       = 2;
   localparam int unsigned INVULN_FRAMES = 60;
`ifdef COLLISION_INVULN_EN
   localparam bit INV_ON = 1'b1;
`else
   localparam bit INV_ON = 1'b0;
`endif
   localparam int NVEC = 13;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_tick;
   logic        restart;
   logic [9:0]  player_x;
   logic [9:0]  player_y;
   logic [39:0] car_x;
   logic        hit;
   logic [2:0]  hit_car;
   logic        respawn;
   logic [1:0]  lives;
   logic        invuln;
   logic        game_over;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0]  px;
      logic [9:0]  py;
      logic [39:0] cx;
      logic        exp_hit;
      logic [2:0]  exp_car;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   collision_sequencer #(
      .NUM_CARS      (NUM_CARS),
      .START_LIVES   (START_LIVES),
      .LIVES_W       (LIVES_W),
      .INVULN_FRAMES (INVULN_FRAMES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .restart    (restart),
      .player_x   (player_x),
      .player_y   (player_y),
      .car_x      (car_x),
      .hit        (hit),
      .hit_car    (hit_car),
      .respawn    (respawn),
      .lives      (lives),
      .invuln     (invuln),
      .game_over  (game_over),
      .busy       (busy),
      .overrun    (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [39:0] cars(input logic [9:0] c0, input logic [9:0] c1,
                                        input logic [9:0] c2, input logic [9:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic do_restart();
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
   endtask

   // Pulse a tick and sample outputs one cycle after the DECIDE edge.
   task automatic frame(output logic h, output logic r, output logic [2:0] hc, output logic early);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      early = hit;
      repeat (4) begin
         @(negedge clk);
         if (hit) early = 1'b1;
      end
      @(negedge clk);
      h  = hit;
      r  = respawn;
      hc = hit_car;
   endtask

   initial begin
      logic       h, r, early;
      logic [2:0] hc;
      int         m_lives, m_inv, nhits, third, nh;
      logic       m_go, exp_h;

      vecs[0]  = '{10'd50,   10'd100, cars(10'd60,  10'd900, 10'd900, 10'd900),  1'b1, 3'd0};
      vecs[1]  = '{10'd92,   10'd100, cars(10'd60,  10'd900, 10'd900, 10'd900),  1'b0, 3'd0};
      vecs[2]  = '{10'd91,   10'd100, cars(10'd60,  10'd900, 10'd900, 10'd900),  1'b1, 3'd0};
      vecs[3]  = '{10'd28,   10'd100, cars(10'd60,  10'd900, 10'd900, 10'd900),  1'b0, 3'd0};
      vecs[4]  = '{10'd29,   10'd100, cars(10'd60,  10'd900, 10'd900, 10'd900),  1'b1, 3'd0};
      vecs[5]  = '{10'd50,   10'd68,  cars(10'd50,  10'd900, 10'd900, 10'd900),  1'b0, 3'd0};
      vecs[6]  = '{10'd50,   10'd69,  cars(10'd50,  10'd900, 10'd900, 10'd900),  1'b1, 3'd0};
      vecs[7]  = '{10'd50,   10'd132, cars(10'd50,  10'd900, 10'd900, 10'd900),  1'b0, 3'd0};
      vecs[8]  = '{10'd50,   10'd180, cars(10'd900, 10'd50,  10'd900, 10'd900),  1'b1, 3'd1};
      vecs[9]  = '{10'd50,   10'd340, cars(10'd900, 10'd900, 10'd900, 10'd60),   1'b1, 3'd3};
      vecs[10] = '{10'd1010, 10'd340, cars(10'd900, 10'd900, 10'd900, 10'd1000), 1'b1, 3'd3};
      vecs[11] = '{10'd500,  10'd500, cars(10'd60,  10'd60,  10'd60,  10'd60),   1'b0, 3'd0};
      vecs[12] = '{10'd0,    10'd0,   cars(10'd0,   10'd0,   10'd0,   10'd0),    1'b0, 3'd0};

      rst_n = 1'b0; frame_tick = 1'b0; restart = 1'b0;
      player_x = '0; player_y = '0; car_x = '0;
      repeat (2) @(negedge clk);
      check("rst_hit",       32'(hit),       32'd0);
      check("rst_respawn",   32'(respawn),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_lives",     32'(lives),     32'd3);
      check("rst_game_over", 32'(game_over), 32'd0);
      check("rst_invuln",    32'(invuln),    32'd0);
      check("rst_overrun",   32'(overrun),   32'd0);
      check("rst_hit_car",   32'(hit_car),   32'd0);
      rst_n = 1'b1;

      // Overlap vector table, each from a fresh game.
      for (int i = 0; i < NVEC; i++) begin
         do_restart();
         player_x = vecs[i].px; player_y = vecs[i].py; car_x = vecs[i].cx;
         frame(h, r, hc, early);
         check($sformatf("vec%0d_hit", i),     32'(h), 32'(vecs[i].exp_hit));
         check($sformatf("vec%0d_respawn", i), 32'(r), 32'(vecs[i].exp_hit));
         check($sformatf("vec%0d_lives", i),   32'(lives), vecs[i].exp_hit ? 32'd2 : 32'd3);
         if (vecs[i].exp_hit) check($sformatf("vec%0d_hit_car", i), 32'(hc), 32'(vecs[i].exp_car));
      end

      // Exact latency and pulse width of a hit.
      do_restart();
      player_x = 10'd50; player_y = 10'd100; car_x = cars(10'd60, 10'd900, 10'd900, 10'd900);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      check("lat_busy_rise", 32'(busy), 32'd1);
      early = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (hit) early = 1'b1;
      end
      check("lat_no_early_hit", 32'(early), 32'd0);
      @(negedge clk);
      check("lat_hit",     32'(hit),     32'd1);
      check("lat_respawn", 32'(respawn), 32'd1);
      check("lat_lives",   32'(lives),   32'd2);
      check("lat_invuln",  32'(invuln),  32'(INV_ON));
      check("lat_busy",    32'(busy),    32'd0);
      @(negedge clk);
      check("lat_hit_width",     32'(hit),     32'd0);
      check("lat_respawn_width", 32'(respawn), 32'd0);

      // Held overlap on car1 until game over; invulnerability masks frames between hits.
      do_restart();
      player_x = 10'd50; player_y = 10'd180; car_x = cars(10'd900, 10'd50, 10'd900, 10'd900);
      m_lives = 3; m_inv = 0; m_go = 1'b0; nhits = 0; third = -1;
      for (int f = 1; f <= 130; f++) begin
         exp_h = !m_go && (m_inv == 0);
         if (!m_go) begin
            if (m_inv != 0) m_inv--;
            else begin
               m_lives--; nhits++;
               if (nhits == 3) third = f;
               if (m_lives == 0) m_go = 1'b1;
               else if (INV_ON) m_inv = int'(INVULN_FRAMES);
            end
         end
         frame(h, r, hc, early);
         check($sformatf("seq%0d_hit", f),       32'(h),         32'(exp_h));
         check($sformatf("seq%0d_respawn", f),   32'(r),         32'(exp_h && !m_go));
         check($sformatf("seq%0d_lives", f),     32'(lives),     32'(m_lives));
         check($sformatf("seq%0d_game_over", f), 32'(game_over), 32'(m_go));
         check($sformatf("seq%0d_invuln", f),    32'(invuln),    32'(m_inv != 0));
         if (exp_h) check($sformatf("seq%0d_hit_car", f), 32'(hc), 32'd1);
      end
      check("seq_third_hit_frame", 32'(third), INV_ON ? 32'd123 : 32'd3);
      do_restart();
      @(negedge clk);
      check("rs_lives",     32'(lives),     32'd3);
      check("rs_game_over", 32'(game_over), 32'd0);
      check("rs_invuln",    32'(invuln),    32'd0);

      // Tick while busy: dropped, overrun set, only one decide.
      do_restart();
      player_x = 10'd50; player_y = 10'd100; car_x = cars(10'd60, 10'd900, 10'd900, 10'd900);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      nh = 0;
      repeat (12) begin
         @(negedge clk);
         if (hit) nh++;
      end
      check("ovr_overrun", 32'(overrun), 32'd1);
      check("ovr_one_hit", 32'(nh),      32'd1);
      check("ovr_busy",    32'(busy),    32'd0);
      do_restart();
      check("ovr_cleared", 32'(overrun), 32'd0);

      // Restart during SCAN aborts the overlapping frame.
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      nh = 0;
      repeat (8) begin
         @(negedge clk);
         if (hit) nh++;
      end
      check("abort_no_hit", 32'(nh),    32'd0);
      check("abort_lives",  32'(lives), 32'd3);

      // Restart together with a tick drops the tick.
      @(negedge clk) begin frame_tick = 1'b1; restart = 1'b1; end
      @(negedge clk) begin frame_tick = 1'b0; restart = 1'b0; end
      check("rt_tick_busy", 32'(busy), 32'd0);
      nh = 0;
      repeat (8) begin
         @(negedge clk);
         if (hit) nh++;
      end
      check("rt_tick_no_hit", 32'(nh), 32'd0);

      // Asynchronous reset mid-scan after a hit on car3.
      do_restart();
      player_x = 10'd50; player_y = 10'd340; car_x = cars(10'd900, 10'd900, 10'd900, 10'd60);
      frame(h, r, hc, early);
      check("ar_pre_hit_car", 32'(hc), 32'd3);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_hit",       32'(hit),       32'd0);
      check("ar_respawn",   32'(respawn),   32'd0);
      check("ar_busy",      32'(busy),      32'd0);
      check("ar_lives",     32'(lives),     32'd3);
      check("ar_hit_car",   32'(hit_car),   32'd0);
      check("ar_invuln",    32'(invuln),    32'd0);
      check("ar_game_over", 32'(game_over), 32'd0);
      check("ar_overrun",   32'(overrun),   32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
